// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the ID/EX/MEM datapath and
// the hazard unit.
interface hazard_stall_unit_if;
  logic        re_mem_EX;
  logic        we_rf_EX;
  logic [3:0]  dst_addr_EX;
  logic [3:0]  p0_addr_ID;
  logic [3:0]  p1_addr_ID;
  logic        p0_used_ID;
  logic        p1_used_ID;
  logic        branch_taken_EX;
  logic        mem_busy;
  logic        stall_IF_ID;
  logic        bubble_ID_EX;
  logic        flush_IF_ID;
  logic        freeze;
  logic [15:0] stall_cnt;

  modport master (
    output re_mem_EX, we_rf_EX, dst_addr_EX,
    output p0_addr_ID, p1_addr_ID,
    output p0_used_ID, p1_used_ID,
    output branch_taken_EX, mem_busy,
    input  stall_IF_ID, bubble_ID_EX,
    input  flush_IF_ID, freeze, stall_cnt
  );

  modport slave (
    input  re_mem_EX, we_rf_EX, dst_addr_EX,
    input  p0_addr_ID, p1_addr_ID,
    input  p0_used_ID, p1_used_ID,
    input  branch_taken_EX, mem_busy,
    output stall_IF_ID, bubble_ID_EX,
    output flush_IF_ID, freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, memory freeze.
// Optional stall counter enabled by HAZARD_STALL_CNT_EN.
module hazard_stall_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic clk,
    input logic rst_n,
    hazard_stall_unit_if.slave hz
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        MWAIT
    } state_t;

    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    state_t     eff;
    logic [1:0] fcnt_q;
    logic [1:0] fcnt_d;
    logic       p0_hit;
    logic       p1_hit;
    logic       lu;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       frz;

    assign p0_hit = hz.p0_used_ID
                  & (hz.p0_addr_ID == hz.dst_addr_EX);
    assign p1_hit = hz.p1_used_ID
                  & (hz.p1_addr_ID == hz.dst_addr_EX);
    assign lu = hz.re_mem_EX & hz.we_rf_EX
              & (hz.dst_addr_EX != 4'd0)
              & (p0_hit | p1_hit);

    always_comb begin
        // Leaving MWAIT re-evaluates inputs in the same cycle
        eff = state_q;
        if (state_q == MWAIT && !hz.mem_busy) begin
            eff = (fcnt_q != 2'd0) ? FLUSH : RUN;
        end
        state_d = state_q;
        fcnt_d  = fcnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        frz     = 1'b0;
        case (eff)
            RUN: begin
                state_d = RUN;
                if (hz.mem_busy) begin
                    frz     = 1'b1;
                    state_d = MWAIT;
                end else if (hz.branch_taken_EX) begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    fcnt_d  = FC_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (lu) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            FLUSH: begin
                if (hz.mem_busy) begin
                    frz     = 1'b1;
                    state_d = MWAIT;
                end else begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    fcnt_d  = fcnt_q - 2'd1;
                    state_d = (fcnt_q <= 2'd1) ? RUN : FLUSH;
                end
            end
            MWAIT: begin
                frz     = 1'b1;
                state_d = MWAIT;
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign hz.stall_IF_ID  = rst_n & stall;
    assign hz.bubble_ID_EX = rst_n & bubble;
    assign hz.flush_IF_ID  = rst_n & flush;
    assign hz.freeze       = rst_n & frz;

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if ((stall | frz) && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign hz.stall_cnt = cnt_q;
`else
    assign hz.stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3: number of cycles flush is held after a taken branch/jump.
REQ-002 SHALL have port clk  input  1  the single system clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port re_mem_EX  input  1  instruction in EX is a load.
REQ-005 SHALL have port we_rf_EX  input  1  instruction in EX writes the register file.
REQ-006 SHALL have port dst_addr_EX  input  4  destination register of the EX instruction.
REQ-007 SHALL have ports p0_addr_ID and p1_addr_ID  input  4 each  source registers of the ID instruction.
REQ-008 SHALL have ports p0_used_ID and p1_used_ID  input  1 each  the ID instruction actually reads that source.
REQ-009 SHALL have port branch_taken_EX  input  1  taken branch/jump resolved in EX this cycle.
REQ-010 SHALL have port mem_busy  input  1  data memory not ready; the whole pipeline must freeze.
REQ-011 SHALL have port stall_IF_ID  output  1  hold PC and the IF/ID register.
REQ-012 SHALL have port bubble_ID_EX  output  1  load a NOP into ID/EX (we_rf, re_mem, we_mem cleared).
REQ-013 SHALL have port flush_IF_ID  output  1  replace the IF/ID contents with a NOP.
REQ-014 SHALL have port freeze  output  1  hold every pipeline register and the PC.
REQ-015 SHALL have port stall_cnt  output  16  count of stall cycles.

Function
REQ-016 SHALL detect a load-use hazard, lu = re_mem_EX & we_rf_EX & (dst_addr_EX != 0) & ((p0_used_ID & p0_addr_ID == dst_addr_EX) | (p1_used_ID & p1_addr_ID == dst_addr_EX)).
REQ-017 SHALL use an FSM with states RUN, FLUSH, MWAIT; the outputs are a combinational function of the state and the current inputs.
REQ-018 In RUN with mem_busy=1: SHALL assert freeze, with all other outputs 0; next state MWAIT.
REQ-019 In RUN with mem_busy=0 and branch_taken_EX=1: SHALL assert flush_IF_ID and bubble_ID_EX, and stall_IF_ID=0. The counter loads FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-020 In RUN with mem_busy=0, branch_taken_EX=0 and lu=1: SHALL assert stall_IF_ID and bubble_ID_EX for exactly that cycle; next state RUN.
REQ-021 The load-use stall SHALL be one cycle only; the load then sits in MEM, where the existing ldata-from-MEM forwarding path supplies it.
REQ-022 In FLUSH: SHALL assert flush_IF_ID and bubble_ID_EX and decrement the counter. On reaching 0, next state is RUN. mem_busy=1 in FLUSH SHALL take priority: freeze only, remaining flush count held, next state MWAIT.
REQ-023 In MWAIT: SHALL assert freeze only. branch_taken_EX and lu SHALL be ignored. When mem_busy=0, next state is FLUSH if the flush count is nonzero, else RUN, and the inputs are re-evaluated in that cycle per REQ-018..022.
REQ-024 Priority SHALL be mem_busy > branch_taken_EX > lu; a simultaneous branch and load-use SHALL flush and never stall.
REQ-025 Hazards on register 0 SHALL never stall.

Reset
REQ-026 On a rising clk edge with rst_n=0: SHALL set state to RUN, the flush counter to 0 and stall_cnt to 0, including mid-FLUSH and mid-MWAIT.
REQ-027 While rst_n=0: all outputs SHALL be 0 except stall_cnt, which reads 0 after the first reset edge.

Configuration
REQ-028 Macro HAZARD_STALL_CNT_EN, when defined: stall_cnt SHALL increment by 1 on each cycle with stall_IF_ID|freeze=1, saturating at 16'hFFFF.
REQ-029 Macro HAZARD_STALL_CNT_EN, when undefined: stall_cnt SHALL be constant 16'h0000 and no counter register SHALL be built; all other behaviour is identical.

Verification
REQ-030 Load-use: re_mem_EX=1, we_rf_EX=1, dst_addr_EX=4'h3, p1_used_ID=1, p1_addr_ID=4'h3 -> stall_IF_ID=1 and bubble_ID_EX=1 for one cycle; next cycle (EX bubble) all outputs 0.
REQ-031 Register 0 and unused source: dst_addr_EX=0 with a matching source -> no stall. dst=4'h5 matching p0_addr_ID with p0_used_ID=0 -> no stall.
REQ-032 Branch with FLUSH_CYCLES=2: branch_taken_EX pulse -> flush_IF_ID=1 and bubble_ID_EX=1 for exactly 2 cycles, then all outputs 0. The same pulse together with lu=1 -> stall_IF_ID stays 0.
REQ-033 Memory wait: mem_busy=1 for 3 cycles arriving in the FLUSH cycle 1 of 2 -> freeze=1 for 3 cycles, then 1 remaining flush cycle, then RUN.
REQ-034 Reset mid-MWAIT: rst_n=0 for one edge while mem_busy=1 -> next cycle state RUN and stall_cnt=0. With mem_busy still 1 -> freeze=1 again via the RUN rule.
REQ-035 Counter (macro defined): 5 load-use stalls plus 3 freeze cycles -> stall_cnt=8. Counter forced near 16'hFFFE plus 3 stall cycles -> holds 16'hFFFF. Macro undefined -> stall_cnt=0 throughout.
